dual_port_data_mem: RTL and testbench



---
 rtl/dual_port_data_mem.sv | 131 +++++++++++++
 tb/tb_dual_port_data_mem.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_data_mem.sv
// dual_port_data_mem: dual-port RAM with one-cycle read-first responses; DPMEM_ADDR_CHECK_EN enables out-of-range errors
module dual_port_data_mem_array #(
  parameter int DATA_WIDTH   = 32,
  parameter int M_ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic [M_ADDR_WIDTH-1:0] idx_a,
  input  logic [M_ADDR_WIDTH-1:0] idx_b,
  input  logic [DATA_WIDTH/8-1:0] wen_a,
  input  logic [DATA_WIDTH/8-1:0] wen_b,
  input  logic [DATA_WIDTH-1:0]   wdata_a,
  input  logic [DATA_WIDTH-1:0]   wdata_b,
  output logic [DATA_WIDTH-1:0]   rdata_a,
  output logic [DATA_WIDTH-1:0]   rdata_b
);
  logic [DATA_WIDTH-1:0] mem [2**M_ADDR_WIDTH];
  // port A is applied last so it wins any byte both ports write on the same edge
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (wen_b[i]) mem[idx_b][8*i +: 8] <= wdata_b[8*i +: 8];
      if (wen_a[i]) mem[idx_a][8*i +: 8] <= wdata_a[8*i +: 8];
    end
  end
  assign rdata_a = mem[idx_a];
  assign rdata_b = mem[idx_b];
endmodule

module dual_port_data_mem #(
  parameter int DATA_WIDTH   = 32,
  parameter int M_ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    data_req_a,
  input  logic [31:0]             data_addr_a,
  input  logic                    data_we_a,
  input  logic [DATA_WIDTH/8-1:0] data_be_a,
  input  logic [DATA_WIDTH-1:0]   data_wdata_a,
  output logic                    data_gnt_a,
  output logic                    data_rvalid_a,
  output logic                    data_err_a,
  output logic [DATA_WIDTH-1:0]   data_rdata_a,
  input  logic                    data_req_b,
  input  logic [31:0]             data_addr_b,
  input  logic                    data_we_b,
  input  logic [DATA_WIDTH/8-1:0] data_be_b,
  input  logic [DATA_WIDTH-1:0]   data_wdata_b,
  output logic                    data_gnt_b,
  output logic                    data_rvalid_b,
  output logic                    data_err_b,
  output logic [DATA_WIDTH-1:0]   data_rdata_b
);
  localparam int BW = DATA_WIDTH/8;
  logic [M_ADDR_WIDTH-1:0] idx_a, idx_b;
  logic                    oor_a, oor_b;
  logic [BW-1:0]           wen_a, wen_b;
  logic [DATA_WIDTH-1:0]   mem_rdata_a, mem_rdata_b;
  logic                    rvalid_a_d, rvalid_a_q, rvalid_b_d, rvalid_b_q;
  logic                    err_a_d, err_a_q, err_b_d, err_b_q;
  logic [DATA_WIDTH-1:0]   rdata_a_d, rdata_a_q, rdata_b_d, rdata_b_q;
  logic                    unused_addr;

  always_comb begin
    idx_a = data_addr_a[M_ADDR_WIDTH+1:2];
    idx_b = data_addr_b[M_ADDR_WIDTH+1:2];
`ifdef DPMEM_ADDR_CHECK_EN
    oor_a = |data_addr_a[31:M_ADDR_WIDTH+2];
    oor_b = |data_addr_b[31:M_ADDR_WIDTH+2];
`else
    oor_a = 1'b0;
    oor_b = 1'b0;
`endif
    wen_a      = (rst_ni && data_req_a && data_we_a && !oor_a) ? data_be_a : '0;
    wen_b      = (rst_ni && data_req_b && data_we_b && !oor_b) ? data_be_b : '0;
    rvalid_a_d = data_req_a;
    rvalid_b_d = data_req_b;
    err_a_d    = data_req_a & oor_a;
    err_b_d    = data_req_b & oor_b;
    rdata_a_d  = data_req_a ? mem_rdata_a : rdata_a_q;
    rdata_b_d  = data_req_b ? mem_rdata_b : rdata_b_q;
  end

`ifdef DPMEM_ADDR_CHECK_EN
  assign unused_addr = ^{data_addr_a[1:0], data_addr_b[1:0]};
`else
  assign unused_addr = ^{data_addr_a[1:0], data_addr_b[1:0],
                         data_addr_a[31:M_ADDR_WIDTH+2], data_addr_b[31:M_ADDR_WIDTH+2]};
`endif

  dual_port_data_mem_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .M_ADDR_WIDTH(M_ADDR_WIDTH)
  ) MX (
    .clk    (clk),
    .idx_a  (idx_a),
    .idx_b  (idx_b),
    .wen_a  (wen_a),
    .wen_b  (wen_b),
    .wdata_a(data_wdata_a),
    .wdata_b(data_wdata_b),
    .rdata_a(mem_rdata_a),
    .rdata_b(mem_rdata_b)
  );

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      err_a_q    <= 1'b0;
      err_b_q    <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      err_a_q    <= err_a_d;
      err_b_q    <= err_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
    end
  end

  assign data_gnt_a    = data_req_a;
  assign data_gnt_b    = data_req_b;
  assign data_rvalid_a = rvalid_a_q;
  assign data_rvalid_b = rvalid_b_q;
  assign data_err_a    = err_a_q;
  assign data_err_b    = err_b_q;
  assign data_rdata_a  = rdata_a_q;
  assign data_rdata_b  = rdata_b_q;
endmodule

// File: tb/tb_dual_port_data_mem.sv
// tb_dual_port_data_mem: directed checks of handshake, byte enables, collisions, range errors and reset
module tb_dual_port_data_mem;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_a, we_a, req_b, we_b;
  logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
  logic [3:0]  be_a, be_b;
  logic        gnt_a, rvalid_a, err_a, gnt_b, rvalid_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dual_port_data_mem dut (
    .clk          (clk),
    .rst_ni       (rst_ni),
    .data_req_a   (req_a),
    .data_addr_a  (addr_a),
    .data_we_a    (we_a),
    .data_be_a    (be_a),
    .data_wdata_a (wdata_a),
    .data_gnt_a   (gnt_a),
    .data_rvalid_a(rvalid_a),
    .data_err_a   (err_a),
    .data_rdata_a (rdata_a),
    .data_req_b   (req_b),
    .data_addr_b  (addr_b),
    .data_we_b    (we_b),
    .data_be_b    (be_b),
    .data_wdata_b (wdata_b),
    .data_gnt_b   (gnt_b),
    .data_rvalid_b(rvalid_b),
    .data_err_b   (err_b),
    .data_rdata_b (rdata_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    req_a = 1'b1; we_a = we; be_a = be; addr_a = addr; wdata_a = wd;
  endtask

  task automatic drv_b(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    req_b = 1'b1; we_b = we; be_b = be; addr_b = addr; wdata_b = wd;
  endtask

  task automatic idle;
    req_a = 1'b0; we_a = 1'b0; be_a = '0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; be_b = '0; addr_b = '0; wdata_b = '0;
  endtask

  task automatic wr_a(input logic [31:0] addr, input logic [31:0] wd);
    drv_a(1'b1, 4'hF, addr, wd);
    cyc;
    idle;
  endtask

  initial begin
    logic [31:0] exp_err, exp_alias;
`ifdef DPMEM_ADDR_CHECK_EN
    exp_err   = 32'd1;
    exp_alias = 32'h0000_0013;
`else
    exp_err   = 32'd0;
    exp_alias = 32'hDEAD_BEEF;
`endif
    idle;
    rst_ni = 1'b0;
    #2;
    chk("rst_rvalid_a", {31'd0, rvalid_a}, 32'd0);
    chk("rst_err_a", {31'd0, err_a}, 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_rvalid_b", {31'd0, rvalid_b}, 32'd0);
    cyc;
    cyc;
    rst_ni = 1'b1;
    wr_a(32'h0, 32'h0000_0013);
    chk("wr_rsp_rvalid", {31'd0, rvalid_a}, 32'd1);
    wr_a(32'h100, 32'h1122_3344);
    wr_a(32'h4, 32'hA1A1_A1A1);
    wr_a(32'h8, 32'hB2B2_B2B2);
    wr_a(32'hC, 32'hC3C3_C3C3);
    wr_a(32'h40, 32'h5555_5555);
    cyc;
    chk("idle_rvalid", {31'd0, rvalid_a}, 32'd0);

    drv_a(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("gnt_a", {31'd0, gnt_a}, 32'd1);
    cyc;
    idle;
    chk("rd0_rvalid", {31'd0, rvalid_a}, 32'd1);
    chk("rd0_rdata", rdata_a, 32'h0000_0013);
    chk("rd0_err", {31'd0, err_a}, 32'd0);

    drv_a(1'b1, 4'b0101, 32'h100, 32'hAABB_CCDD);
    cyc;
    idle;
    chk("be_wr_rvalid", {31'd0, rvalid_a}, 32'd1);
    chk("be_wr_olddata", rdata_a, 32'h1122_3344);
    drv_a(1'b0, 4'h0, 32'h100, 32'h0);
    cyc;
    idle;
    chk("be_rd", rdata_a, 32'h11BB_33DD);

    drv_a(1'b0, 4'h0, 32'h4, 32'h0);
    cyc;
    chk("b2b0_rvalid", {31'd0, rvalid_a}, 32'd1);
    chk("b2b0_rdata", rdata_a, 32'hA1A1_A1A1);
    addr_a = 32'h8;
    cyc;
    chk("b2b1_rvalid", {31'd0, rvalid_a}, 32'd1);
    chk("b2b1_rdata", rdata_a, 32'hB2B2_B2B2);
    addr_a = 32'hE;
    cyc;
    idle;
    chk("b2b2_rvalid", {31'd0, rvalid_a}, 32'd1);
    chk("b2b2_rdata", rdata_a, 32'hC3C3_C3C3);
    cyc;
    chk("hold_rvalid", {31'd0, rvalid_a}, 32'd0);
    chk("hold_rdata", rdata_a, 32'hC3C3_C3C3);

    drv_a(1'b1, 4'hF, 32'h40, 32'h1);
    drv_b(1'b1, 4'hF, 32'h40, 32'h2);
    #1;
    chk("gnt_b", {31'd0, gnt_b}, 32'd1);
    cyc;
    idle;
    chk("col_rsp_b_rvalid", {31'd0, rvalid_b}, 32'd1);
    chk("col_rsp_b_old", rdata_b, 32'h5555_5555);
    drv_b(1'b0, 4'h0, 32'h40, 32'h0);
    cyc;
    idle;
    chk("col_full_awins", rdata_b, 32'h0000_0001);

    drv_a(1'b1, 4'b0011, 32'h40, 32'hAAAA_1111);
    drv_b(1'b1, 4'b1110, 32'h40, 32'h2222_2222);
    cyc;
    idle;
    drv_a(1'b0, 4'h0, 32'h40, 32'h0);
    cyc;
    idle;
    chk("col_partial", rdata_a, 32'h2222_1111);

    drv_a(1'b1, 4'hF, 32'h40, 32'h7777_7777);
    drv_b(1'b0, 4'h0, 32'h40, 32'h0);
    cyc;
    idle;
    chk("rw_col_b_old", rdata_b, 32'h2222_1111);
    drv_b(1'b0, 4'h0, 32'h40, 32'h0);
    cyc;
    idle;
    chk("rw_col_b_new", rdata_b, 32'h7777_7777);

    drv_a(1'b0, 4'h0, 32'h0004_0000, 32'h0);
    cyc;
    idle;
    chk("oor_rd_rvalid", {31'd0, rvalid_a}, 32'd1);
    chk("oor_rd_err", {31'd0, err_a}, exp_err);
    drv_a(1'b1, 4'hF, 32'h0004_0000, 32'hDEAD_BEEF);
    cyc;
    idle;
    chk("oor_wr_err", {31'd0, err_a}, exp_err);
    drv_b(1'b0, 4'h0, 32'h0, 32'h0);
    cyc;
    idle;
    chk("oor_wr_mem0", rdata_b, exp_alias);
    chk("inrange_err_b", {31'd0, err_b}, 32'd0);

    drv_a(1'b0, 4'h0, 32'h100, 32'h0);
    cyc;
    chk("pre_rst_rvalid", {31'd0, rvalid_a}, 32'd1);
    drv_a(1'b1, 4'hF, 32'h100, 32'h0);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_rvalid", {31'd0, rvalid_a}, 32'd0);
    chk("async_rst_rdata", rdata_a, 32'd0);
    cyc;
    chk("in_rst_rvalid", {31'd0, rvalid_a}, 32'd0);
    idle;
    #2;
    rst_ni = 1'b1;
    drv_a(1'b0, 4'h0, 32'h100, 32'h0);
    cyc;
    chk("post_rst_rvalid", {31'd0, rvalid_a}, 32'd1);
    chk("post_rst_rdata", rdata_a, 32'h11BB_33DD);
    addr_a = 32'h4;
    cyc;
    idle;
    chk("post_rst_rdata4", rdata_a, 32'hA1A1_A1A1);
    cyc;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
